serial_subtractor: RTL



---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 106 ++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the serial subtractor.
// The controller drives the request side and the subtractor drives the result side.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Diff;
   logic             Bout;
   logic             Overflow;

   modport master (
      output start, A, B,
      input  busy, done, Diff, Bout, Overflow
   );

   modport slave (
      input  start, A, B,
      output busy, done, Diff, Bout, Overflow
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B, LSB first, one full-subtractor cell
// and a registered borrow. WIDTH clocks from accept to result, with a
// one-cycle DONE state in which a new operation may be issued.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   serial_subtractor_if.slave bus
);
   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] r_sr;
   logic             bw;
   logic [CNT_W-1:0] cnt;
   logic             a_sign;
   logic             b_sign;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
   logic             ovf_q;

   logic             accept;
   logic             d;
   logic             bw_next;

   // Full-subtractor difference bit
   function automatic logic fs_diff(input logic a, input logic b, input logic bi);
      return a ^ b ^ bi;
   endfunction

   // Full-subtractor borrow-out
   function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
      return (~a & b) | (~(a ^ b) & bi);
   endfunction

   // Single subtractor cell on the current LSBs and the accept condition
   always_comb begin
      d       = fs_diff(a_sr[0], b_sr[0], bw);
      bw_next = fs_borrow(a_sr[0], b_sr[0], bw);
      accept  = bus.start && ((state == S_IDLE) || (state == S_DONE));
   end

   // Control FSM, operand/result shifting and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         r_sr   <= '0;
         bw     <= 1'b0;
         cnt    <= '0;
         a_sign <= 1'b0;
         b_sign <= 1'b0;
         diff_q <= '0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         case (state)
            S_RUN: begin
               bw   <= bw_next;
               r_sr <= {d, r_sr[WIDTH-1:1]};
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // d is the MSB of the finished difference here
                  diff_q <= {d, r_sr[WIDTH-1:1]};
                  bout_q <= bw_next;
                  ovf_q  <= (a_sign ^ b_sign) & (d ^ a_sign);
                  state  <= S_DONE;
               end
            end
            default: begin
               if (accept) begin
                  a_sr   <= bus.A;
                  b_sr   <= bus.B;
                  bw     <= 1'b0;
                  cnt    <= '0;
                  a_sign <= bus.A[WIDTH-1];
                  b_sign <= bus.B[WIDTH-1];
                  state  <= S_RUN;
               end else begin
                  state  <= S_IDLE;
               end
            end
         endcase
      end
   end

   // Status flags decode directly from the state register
   always_comb begin
      bus.busy     = (state == S_RUN);
      bus.done     = (state == S_DONE);
      bus.Diff     = diff_q;
      bus.Bout     = bout_q;
      bus.Overflow = ovf_q;
   end
endmodule
